// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte-level transforms for the iterative encryption core.
// State and round-key words use FIPS-197 order: byte 0 in bits [127:120], column c in bits [127-32c -: 32].
package aes_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_t;

  localparam int NR_128 = 10;
  localparam int NR_256 = 14;

  // Forward S-box, byte 0x00 at the most significant end.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int nr_of(input int key_bits);
    return (key_bits == 256) ? NR_256 : NR_128;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
    return r;
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
    return r;
  endfunction

  function automatic logic [127:0] chain_words(input logic [127:0] prev, input logic [31:0] temp);
    logic [31:0] n0, n1, n2, n3;
    n0 = prev[127:96] ^ temp;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = prev[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] expand_128(input logic [127:0] prev, input logic [7:0] rc);
    return chain_words(prev, sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h0});
  endfunction

  // Builds rk[j] from rk[j-2] (ka) and rk[j-1] (kb); odd j skips rotation and Rcon.
  function automatic logic [127:0] expand_256(input logic [127:0] ka, input logic [127:0] kb,
                                              input logic [3:0] j);
    logic [31:0] temp;
    if (j[0]) temp = sub_word(kb[31:0]);
    else      temp = sub_word({kb[23:0], kb[31:24]}) ^ {rcon({1'b0, j[3:1]}), 24'h0};
    return chain_words(ka, temp);
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] shifted;

  always_comb begin
    shifted   = shift_rows(sub_bytes(state_in));
    state_out = (last ? shifted : mix_columns(shifted)) ^ round_key;
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/256 encryption core: one round per clock, on-the-fly key schedule,
// valid/ready handshakes on both sides with same-edge output handoff and next accept.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  input  logic [KEY_BITS-1:0] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data,
  output logic                busy,
  output logic [3:0]          round
);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  localparam logic [3:0] NR     = 4'(nr_of(KEY_BITS));
  localparam bit         IS_256 = (KEY_BITS == 256);

  aes_state_t   state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] key_a_q, key_a_d;
  logic [127:0] key_b_q, key_b_d;
  logic [127:0] round_key, round_out;
  logic         accept, last_round;

  assign accept     = in_valid & in_ready;
  assign last_round = (rnd_q == NR);
  assign out_data   = blk_q;

  aes_round u_round (
    .state_in  (blk_q),
    .round_key (round_key),
    .last      (last_round),
    .state_out (round_out)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROUND;
      ROUND:   if (last_round) state_d = DONE;
      DONE: begin
        if (accept)         state_d = ROUND;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    busy      = (state_q == ROUND);
    round     = (state_q == ROUND) ? rnd_q : 4'd0;
  end

  // AES-128 keeps rk[rnd-1] in key_a and derives rk[rnd] this cycle; AES-256 keeps rk[rnd-1]/rk[rnd] in key_a/key_b.
  always_comb begin
    round_key = IS_256 ? key_b_q : expand_128(key_a_q, rcon(rnd_q));
    rnd_d     = rnd_q;
    blk_d     = blk_q;
    key_a_d   = key_a_q;
    key_b_d   = key_b_q;
    if (accept) begin
      blk_d   = in_data ^ in_key[KEY_BITS-1 -: 128];
      key_a_d = in_key[KEY_BITS-1 -: 128];
      key_b_d = IS_256 ? in_key[127:0] : 128'd0;
      rnd_d   = 4'd1;
    end else if (state_q == ROUND) begin
      blk_d = round_out;
      rnd_d = last_round ? 4'd0 : rnd_q + 4'd1;
      if (IS_256) begin
        key_a_d = key_b_q;
        key_b_d = expand_256(key_a_q, key_b_q, rnd_q + 4'd1);
      end else begin
        key_a_d = round_key;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rnd_q   <= 4'd0;
      blk_q   <= 128'd0;
      key_a_q <= 128'd0;
      key_b_q <= 128'd0;
    end else begin
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      key_a_q <= key_a_d;
      key_b_q <= key_b_d;
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: FIPS-197 vectors, random blocks against a
// GF(2^8)-arithmetic AES model, and handshake / backpressure / reset sequences.
module tb_aes_iter_core;

  typedef struct {
    bit           wide;
    logic [127:0] data;
    logic [255:0] key;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] C1_KEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] B_KEY  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] C3_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clock = 1'b0;
  logic reset_n;

  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [127:0] in_data_a, in_key_a, out_data_a;
  logic [3:0]   round_a;

  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [127:0] in_data_b, out_data_b;
  logic [255:0] in_key_b;
  logic [3:0]   round_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sbox_m [256];

  always #5 clock = ~clock;

  aes_iter_core dut_128 (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .in_data   (in_data_a),
    .in_key    (in_key_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .out_data  (out_data_a),
    .busy      (busy_a),
    .round     (round_a)
  );

  aes_iter_core #(.KEY_BITS(256)) dut_256 (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .in_data   (in_data_b),
    .in_key    (in_key_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .out_data  (out_data_b),
    .busy      (busy_b),
    .round     (round_b)
  );

  // Reference model built from field arithmetic rather than lookup tables.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word_m(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_m[w[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                                 input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  temp;
    logic [7:0]   rc;
    logic [127:0] ct;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = sub_word_m({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        temp = sub_word_m(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int b = 0; b < 16; b++) s[b] = pt[127 - 8*b -: 8];
    for (int r = 0; r <= nr; r++) begin
      if (r > 0) begin
        for (int b = 0; b < 16; b++) s[b] = sbox_m[s[b]];
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) t[row + 4*c] = s[row + 4*((c + row) % 4)];
        s = t;
        if (r < nr) begin
          for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
              t[row + 4*c] = gmul(8'h02, s[4*c + row]) ^ gmul(8'h03, s[4*c + (row + 1) % 4])
                           ^ s[4*c + (row + 2) % 4] ^ s[4*c + (row + 3) % 4];
          s = t;
        end
      end
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) s[4*c + k] = s[4*c + k] ^ w[4*r + c][31 - 8*k -: 8];
    end
    for (int b = 0; b < 16; b++) ct[127 - 8*b -: 8] = s[b];
    return ct;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents one block to an idle core and steps over the accept edge.
  task automatic apply_stimulus(input bit wide, input logic [127:0] data, input logic [255:0] key);
    if (wide) begin
      in_data_b  = data;
      in_key_b   = key;
      in_valid_b = 1'b1;
    end else begin
      in_data_a  = data;
      in_key_a   = key[255:128];
      in_valid_a = 1'b1;
    end
    #1;
    check_output(wide ? "in_ready_256" : "in_ready_128",
                 {127'd0, (wide ? in_ready_b : in_ready_a)}, 128'd1);
    step();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_result(input bit wide, input logic [127:0] exp, input int exp_cycles,
                             input string name);
    int cyc = 0;
    while (!(wide ? out_valid_b : out_valid_a) && cyc < 40) begin
      step();
      cyc++;
    end
    check_output({name, "_latency"}, 128'(cyc), 128'(exp_cycles));
    check_output({name, "_data"}, wide ? out_data_b : out_data_a, exp);
  endtask

  task automatic run_vector(input bit wide, input logic [127:0] data, input logic [255:0] key,
                            input logic [127:0] exp, input string name);
    apply_stimulus(wide, data, key);
    wait_result(wide, exp, wide ? 14 : 10, name);
    step();
  endtask

  initial begin
    vec_t vecs[3];
    logic [127:0] d, e;
    logic [255:0] k;

    vecs[0] = '{1'b0, C1_PT, C1_KEY, C1_CT};
    vecs[1] = '{1'b0, B_PT, B_KEY, B_CT};
    vecs[2] = '{1'b1, C1_PT, C3_KEY, C3_CT};

    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));

    in_valid_a = 1'b0; in_data_a = '0; in_key_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_data_b = '0; in_key_b = '0; out_ready_b = 1'b1;
    reset_n = 1'b0;
    #1;
    check_output("rst_in_ready_128", {127'd0, in_ready_a}, 128'd1);
    check_output("rst_out_valid_128", {127'd0, out_valid_a}, 128'd0);
    check_output("rst_busy_128", {127'd0, busy_a}, 128'd0);
    check_output("rst_round_128", {124'd0, round_a}, 128'd0);
    check_output("rst_out_data_128", out_data_a, 128'd0);
    check_output("rst_in_ready_256", {127'd0, in_ready_b}, 128'd1);
    check_output("rst_out_valid_256", {127'd0, out_valid_b}, 128'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 3; i++)
      run_vector(vecs[i].wide, vecs[i].data, vecs[i].key, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
      e = model_encrypt(d, k, 4);
      run_vector(1'b0, d, k, e, $sformatf("rand128_%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      k = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      e = model_encrypt(d, k, 8);
      run_vector(1'b1, d, k, e, $sformatf("rand256_%0d", i));
    end

    // Round index must step 1..10 and drop to 0 once the result is presented.
    apply_stimulus(1'b0, B_PT, B_KEY);
    for (int i = 1; i <= 10; i++) begin
      check_output($sformatf("round_step_%0d", i), {124'd0, round_a}, 128'(i));
      step();
    end
    check_output("round_done_zero", {124'd0, round_a}, 128'd0);
    check_output("round_done_valid", {127'd0, out_valid_a}, 128'd1);
    check_output("round_done_data", out_data_a, B_CT);
    step();

    // Output held under backpressure, then same-edge handoff to a second block.
    out_ready_a = 1'b0;
    apply_stimulus(1'b0, C1_PT, C1_KEY);
    wait_result(1'b0, C1_CT, 10, "bp_first");
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("bp_hold_data_%0d", i), out_data_a, C1_CT);
      check_output($sformatf("bp_in_ready_%0d", i), {127'd0, in_ready_a}, 128'd0);
      check_output($sformatf("bp_out_valid_%0d", i), {127'd0, out_valid_a}, 128'd1);
      step();
    end
    in_data_a   = B_PT;
    in_key_a    = B_KEY[255:128];
    in_valid_a  = 1'b1;
    out_ready_a = 1'b1;
    #1;
    check_output("b2b_in_ready", {127'd0, in_ready_a}, 128'd1);
    step();
    in_valid_a = 1'b0;
    check_output("b2b_busy", {127'd0, busy_a}, 128'd1);
    check_output("b2b_round", {124'd0, round_a}, 128'd1);
    check_output("b2b_out_valid", {127'd0, out_valid_a}, 128'd0);
    wait_result(1'b0, B_CT, 10, "b2b_second");
    step();

    // Reset in the middle of a block clears everything at once.
    apply_stimulus(1'b0, C1_PT, C1_KEY);
    for (int i = 0; i < 10 && round_a != 4'd4; i++) step();
    check_output("mid_round_is_4", {124'd0, round_a}, 128'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("mid_rst_out_valid", {127'd0, out_valid_a}, 128'd0);
    check_output("mid_rst_busy", {127'd0, busy_a}, 128'd0);
    check_output("mid_rst_round", {124'd0, round_a}, 128'd0);
    check_output("mid_rst_in_ready", {127'd0, in_ready_a}, 128'd1);
    check_output("mid_rst_out_data", out_data_a, 128'd0);
    step();
    check_output("mid_rst_held_in_ready", {127'd0, in_ready_a}, 128'd1);
    reset_n = 1'b1;
    step();
    run_vector(1'b0, C1_PT, C1_KEY, C1_CT, "post_reset_c1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
